// File: rtl/if_fetch_unit_pkg.sv
// Shared widths, encodings and types for the instruction fetch unit.
package if_fetch_unit_pkg;

   localparam int unsigned DATA_SIZE = 32;
   localparam int unsigned INS_SIZE  = 32;

   localparam logic [INS_SIZE-1:0] NOP_INS = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [INS_SIZE-1:0]  ins;
      logic [DATA_SIZE-1:0] pc;
   } fq_entry_t;

   function automatic logic [DATA_SIZE-1:0] next_pc(input logic [DATA_SIZE-1:0] pc);
      return pc + DATA_SIZE'(4);
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO with flush; flush overrides push and pop in the same cycle.
module fetch_queue #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 64,
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             full_c;
   logic             push_ok_c;
   logic             pop_ok_c;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full_c    = (count_q == CNT_W'(DEPTH));
   assign empty     = (count_q == '0);
   assign push_ok_c = push && !full_c;
   assign pop_ok_c  = pop && !empty;
   assign head_data = mem_q[rd_ptr_q];
   assign count     = count_q;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok_c) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
         end
         if (pop_ok_c) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         count_d = count_q + CNT_W'(push_ok_c) - CNT_W'(pop_ok_c);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: one outstanding imem request feeding a small queue toward decode.
module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter logic [DATA_SIZE-1:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned          FQ_DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic                 imem_req,
   output logic [DATA_SIZE-1:0] imem_addr,
   input  logic                 imem_gnt,
   input  logic                 imem_rvalid,
   input  logic [INS_SIZE-1:0]  imem_rdata,
   input  logic                 redirect_valid,
   input  logic [DATA_SIZE-1:0] redirect_pc,
   input  logic                 id_stall,
   output logic                 id_valid,
   output logic [INS_SIZE-1:0]  id_ins,
   output logic [DATA_SIZE-1:0] id_pc
);

   localparam int unsigned CNT_W = $clog2(FQ_DEPTH + 1);

   fetch_state_e         state_q, state_d;
   logic [DATA_SIZE-1:0] pc_q, pc_d;
   logic [DATA_SIZE-1:0] fetch_pc_q, fetch_pc_d;
   logic                 drop_q, drop_d;
   logic                 req_q, req_d;

   logic                 fq_push_c;
   logic                 fq_pop_c;
   logic                 fq_empty;
   logic [CNT_W-1:0]     fq_count;
   fq_entry_t            fq_head;
   fq_entry_t            fq_push_data;
   logic [CNT_W:0]       cnt_after_c;
   logic [DATA_SIZE-1:0] redirect_aligned_c;

   assign fq_pop_c           = !fq_empty && !id_stall;
   assign fq_push_data       = '{ins: imem_rdata, pc: fetch_pc_q};
   assign redirect_aligned_c = {redirect_pc[DATA_SIZE-1:2], 2'b00};
   // Occupancy after this cycle's push/pop; the next fetch needs a spare slot.
   assign cnt_after_c = {1'b0, fq_count} + (CNT_W+1)'(fq_push_c) - (CNT_W+1)'(fq_pop_c);

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      fetch_pc_d = fetch_pc_q;
      drop_d     = drop_q;
      fq_push_c  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (redirect_valid) begin
               pc_d    = redirect_aligned_c;
               state_d = S_REQ;
            end else if (fq_count < CNT_W'(FQ_DEPTH)) begin
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (redirect_valid) begin
               pc_d = redirect_aligned_c;
               if (imem_gnt) begin
                  state_d = S_WAIT;
                  drop_d  = 1'b1;
               end
            end else if (imem_gnt) begin
               fetch_pc_d = pc_q;
               pc_d       = next_pc(pc_q);
               state_d    = S_WAIT;
            end
         end
         S_WAIT: begin
            if (redirect_valid) begin
               pc_d = redirect_aligned_c;
               if (imem_rvalid) begin
                  drop_d  = 1'b0;
                  state_d = S_REQ;
               end else begin
                  drop_d = 1'b1;
               end
            end else if (imem_rvalid) begin
               drop_d = 1'b0;
               if (drop_q) begin
                  state_d = S_REQ;
               end else begin
                  fq_push_c = 1'b1;
                  state_d   = (cnt_after_c < (CNT_W+1)'(FQ_DEPTH)) ? S_REQ : S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      req_d = (state_d == S_REQ);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         fetch_pc_q <= '0;
         drop_q     <= 1'b0;
         req_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         fetch_pc_q <= fetch_pc_d;
         drop_q     <= drop_d;
         req_q      <= req_d;
      end
   end

   fetch_queue #(
      .DEPTH (FQ_DEPTH),
      .WIDTH ($bits(fq_entry_t))
   ) u_fetch_queue (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect_valid),
      .push      (fq_push_c),
      .push_data (fq_push_data),
      .pop       (fq_pop_c),
      .head_data (fq_head),
      .empty     (fq_empty),
      .count     (fq_count)
   );

   assign imem_req  = req_q;
   assign imem_addr = pc_q;
   assign id_valid  = !fq_empty;
   assign id_ins    = fq_empty ? NOP_INS : fq_head.ins;
   assign id_pc     = fq_empty ? '0 : fq_head.pc;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a vector table plus hand-written corner sequences.
module tb_if_fetch_unit;
   import if_fetch_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        id_stall = 1'b0;
   logic        id_valid;
   logic [31:0] id_ins;
   logic [31:0] id_pc;

   int checks   = 0;
   int failures = 0;

   if_fetch_unit dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_stall       (id_stall),
      .id_valid       (id_valid),
      .id_ins         (id_ins),
      .id_pc          (id_pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
      logic        stall;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_ins;
      logic [31:0] e_pc;
   } vec_t;

   vec_t vec [11];

   task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %08h expected %08h", name, got, exp);
      end
   endtask

   task automatic chk(input string tag, input logic e_req, input logic [31:0] e_addr,
                      input logic e_valid, input logic [31:0] e_ins, input logic [31:0] e_pc);
      cmp({tag, ".imem_req"},  32'(imem_req),  32'(e_req));
      cmp({tag, ".imem_addr"}, imem_addr,      e_addr);
      cmp({tag, ".id_valid"},  32'(id_valid),  32'(e_valid));
      cmp({tag, ".id_ins"},    id_ins,         e_ins);
      cmp({tag, ".id_pc"},     id_pc,          e_pc);
   endtask

   task automatic step(input logic g, input logic rv, input logic [31:0] rd,
                       input logic rdr, input logic [31:0] rpc, input logic st);
      imem_gnt       = g;
      imem_rvalid    = rv;
      imem_rdata     = rd;
      redirect_valid = rdr;
      redirect_pc    = rpc;
      id_stall       = st;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      redirect_valid = 1'b0; redirect_pc = '0; id_stall = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk({tag, ".in_reset"}, 1'b0, 32'h0, 1'b0, NOP_INS, 32'h0);
      rst = 1'b0;
   endtask

   initial begin
      // Basic streaming: gnt on request, rvalid the next cycle, then a delayed grant.
      vec[0]  = '{1'b0, 1'b0, 32'h0,          1'b0, 1'b0, 32'h00, 1'b0, NOP_INS,        32'h0};
      vec[1]  = '{1'b1, 1'b0, 32'h0,          1'b0, 1'b1, 32'h00, 1'b0, NOP_INS,        32'h0};
      vec[2]  = '{1'b0, 1'b1, 32'h0000_0093,  1'b0, 1'b0, 32'h04, 1'b0, NOP_INS,        32'h0};
      vec[3]  = '{1'b1, 1'b0, 32'h0,          1'b0, 1'b1, 32'h04, 1'b1, 32'h0000_0093,  32'h0};
      vec[4]  = '{1'b0, 1'b1, 32'h0000_0093,  1'b0, 1'b0, 32'h08, 1'b0, NOP_INS,        32'h0};
      vec[5]  = '{1'b1, 1'b0, 32'h0,          1'b0, 1'b1, 32'h08, 1'b1, 32'h0000_0093,  32'h4};
      vec[6]  = '{1'b0, 1'b1, 32'h0030_0093,  1'b0, 1'b0, 32'h0C, 1'b0, NOP_INS,        32'h0};
      vec[7]  = '{1'b0, 1'b0, 32'h0,          1'b1, 1'b1, 32'h0C, 1'b1, 32'h0030_0093,  32'h8};
      vec[8]  = '{1'b0, 1'b0, 32'h0,          1'b1, 1'b1, 32'h0C, 1'b1, 32'h0030_0093,  32'h8};
      vec[9]  = '{1'b1, 1'b0, 32'h0,          1'b0, 1'b1, 32'h0C, 1'b1, 32'h0030_0093,  32'h8};
      vec[10] = '{1'b0, 1'b0, 32'h0,          1'b0, 1'b0, 32'h10, 1'b0, NOP_INS,        32'h0};

      do_reset("tbl");
      for (int i = 0; i < 11; i++) begin
         chk($sformatf("tbl[%0d]", i), vec[i].e_req, vec[i].e_addr, vec[i].e_valid,
             vec[i].e_ins, vec[i].e_pc);
         step(vec[i].gnt, vec[i].rvalid, vec[i].rdata, 1'b0, 32'h0, vec[i].stall);
      end

      // Decode stall: queue fills to two entries, requests stop until a pop.
      do_reset("stall");
      step(0, 0, 0, 0, 0, 1);
      chk("stall.c1", 1, 32'h0, 0, NOP_INS, 0);
      step(1, 0, 0, 0, 0, 1);
      chk("stall.c2", 0, 32'h4, 0, NOP_INS, 0);
      step(0, 1, 32'h0010_0093, 0, 0, 1);
      chk("stall.c3", 1, 32'h4, 1, 32'h0010_0093, 0);
      step(1, 0, 0, 0, 0, 1);
      chk("stall.c4", 0, 32'h8, 1, 32'h0010_0093, 0);
      step(0, 1, 32'h0020_0093, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("stall.full%0d", i), 0, 32'h8, 1, 32'h0010_0093, 0);
         if (i < 2) step(0, 0, 0, 0, 0, 1);
      end
      step(0, 0, 0, 0, 0, 0);
      chk("stall.pop1", 0, 32'h8, 1, 32'h0020_0093, 32'h4);
      step(0, 0, 0, 0, 0, 1);
      chk("stall.rereq", 1, 32'h8, 1, 32'h0020_0093, 32'h4);
      step(0, 0, 0, 0, 0, 0);
      chk("stall.empty", 1, 32'h8, 0, NOP_INS, 0);

      // Redirect while waiting; the late stale response is discarded.
      do_reset("rdw");
      step(0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      chk("rdw.wait", 0, 32'h4, 0, NOP_INS, 0);
      step(0, 0, 0, 1, 32'h100, 0);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rdw.hold%0d", i), 0, 32'h100, 0, NOP_INS, 0);
         if (i < 2) step(0, 0, 0, 0, 0, 0);
      end
      step(0, 1, 32'hDEAD_0093, 0, 0, 0);
      chk("rdw.req", 1, 32'h100, 0, NOP_INS, 0);
      step(1, 0, 0, 0, 0, 0);
      chk("rdw.wait2", 0, 32'h104, 0, NOP_INS, 0);
      step(0, 1, 32'h0050_0093, 0, 0, 0);
      chk("rdw.ins", 1, 32'h104, 1, 32'h0050_0093, 32'h100);

      // Redirect with rvalid in the same cycle, then redirect with gnt in the same cycle.
      do_reset("rdr");
      step(0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      step(0, 1, 32'hBAD0_0093, 1, 32'h200, 0);
      chk("rdr.req", 1, 32'h200, 0, NOP_INS, 0);
      step(1, 0, 0, 0, 0, 0);
      chk("rdr.wait", 0, 32'h204, 0, NOP_INS, 0);
      step(0, 1, 32'h0070_0093, 0, 0, 0);
      chk("rdr.ins", 1, 32'h204, 1, 32'h0070_0093, 32'h200);
      step(1, 0, 0, 1, 32'h300, 1);
      chk("rdg.wait", 0, 32'h300, 0, NOP_INS, 0);
      step(0, 1, 32'hBAD1_0093, 0, 0, 0);
      chk("rdg.req", 1, 32'h300, 0, NOP_INS, 0);

      // PC wrap at the top of the address space.
      do_reset("wrap");
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 32'hFFFF_FFFC, 0);
      chk("wrap.req", 1, 32'hFFFF_FFFC, 0, NOP_INS, 0);
      step(1, 0, 0, 0, 0, 0);
      chk("wrap.next", 0, 32'h0, 0, NOP_INS, 0);
      step(0, 1, 32'h0090_0093, 0, 0, 0);
      chk("wrap.ins", 1, 32'h0, 1, 32'h0090_0093, 32'hFFFF_FFFC);

      // Asynchronous reset while a fetch is outstanding.
      do_reset("arst");
      step(0, 0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0, 1);
      step(0, 1, 32'h00A0_0093, 0, 0, 1);
      step(1, 0, 0, 0, 0, 1);
      chk("arst.wait", 0, 32'h8, 1, 32'h00A0_0093, 0);
      rst = 1'b1;
      #1;
      chk("arst.now", 0, 32'h0, 0, NOP_INS, 0);
      do_reset("arst2");
      step(0, 0, 0, 0, 0, 0);
      chk("arst.restart", 1, 32'h0, 0, NOP_INS, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter FQ_DEPTH, default 2, fetch-queue entries.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 imem_req  output  1  fetch request valid.
REQ-006 imem_addr  output  data_size  fetch address, word-aligned.
REQ-007 imem_gnt  input  1  request accepted this cycle.
REQ-008 imem_rvalid  input  1  read data valid.
REQ-009 imem_rdata  input  ins_size  fetched instruction.
REQ-010 redirect_valid  input  1  branch/jump redirect from EX.
REQ-011 redirect_pc  input  data_size  redirect target.
REQ-012 id_stall  input  1  decode cannot accept this cycle.
REQ-013 id_valid  output  1  id_ins/id_pc hold a valid instruction.
REQ-014 id_ins  output  ins_size  instruction to decode; 32'h0000_0013 (NOP) when id_valid=0.
REQ-015 id_pc  output  data_size  PC of id_ins.

Function
REQ-016 At most one outstanding fetch; states S_IDLE, S_REQ, S_WAIT.
REQ-017 S_IDLE: imem_req=0; go S_REQ when queue free slots > 0.
REQ-018 S_REQ: imem_req=1, imem_addr=pc; on imem_gnt go S_WAIT, pc <= pc+4.
REQ-019 imem_req and imem_addr stay stable from assertion until imem_gnt unless redirect_valid.
REQ-020 S_WAIT: on imem_rvalid push {rdata, fetch_pc} into queue unless drop flag set; go S_REQ if a slot remains after push, else S_IDLE.
REQ-021 Slot count counts the in-flight fetch as occupied; the queue never overflows.
REQ-022 Queue head drives id_ins/id_pc/id_valid combinationally; pop when id_valid && !id_stall.
REQ-023 Push and pop in the same cycle are both performed; count unchanged.
REQ-024 Empty queue: id_valid=0, id_ins=NOP, id_pc=0.
REQ-025 Queue pointers wrap modulo FQ_DEPTH.
REQ-026 redirect_valid: queue flushed, pc <= redirect_pc, next state S_REQ; takes priority over push, pop and pc+4.
REQ-027 redirect in S_WAIT without rvalid: drop flag set; next rvalid discarded, drop cleared, then S_REQ to redirect_pc.
REQ-028 redirect in S_WAIT with rvalid in the same cycle: data discarded, drop flag not set.
REQ-029 redirect in S_REQ with imem_gnt in the same cycle: go S_WAIT with drop flag set.
REQ-030 Instruction after redirect appears on id_* no earlier than 2 cycles after redirect_valid.
REQ-031 Fetch PC arithmetic is modulo 2^data_size; 32'hFFFF_FFFC+4 wraps to 0.
REQ-032 Best-case latency: imem_rvalid in cycle N gives id_valid in cycle N+1.

Reset
REQ-033 While rst=1: pc=RESET_PC, state=S_IDLE, queue empty, drop=0, imem_req=0, imem_addr=RESET_PC, id_valid=0, id_ins=NOP, id_pc=0.
REQ-034 Reset mid-fetch abandons the outstanding request; the first response after reset is ignored only if the drop flag was set by redirect.

Structure
REQ-035 data_size, ins_size, NOP encoding and state enum belong in the shared parameters package.
REQ-036 Queue is sub-module fetch_queue (synchronous FIFO, parameterised depth/width, flush input).

Verification
REQ-037 Reset release, gnt same cycle, rvalid next cycle, rdata=32'h0000_0093 -> addr 0,4,8 issued; id_ins=32'h0000_0093 with id_pc=0.
REQ-038 id_stall held 5 cycles with continuous responses -> two entries queued, imem_req=0 until a pop, no entry lost or duplicated.
REQ-039 redirect to 32'h0000_0100 in S_WAIT, rvalid 3 cycles later -> stale data dropped; next imem_addr=32'h100; id_pc=32'h100.
REQ-040 redirect and rvalid in the same cycle -> data dropped; following response accepted normally.
REQ-041 pc=32'hFFFF_FFFC fetch -> next imem_addr=32'h0000_0000.
REQ-042 rst asserted in S_WAIT -> all outputs at reset values immediately; fetch restarts from RESET_PC.
